// File: rtl/timer_ctrl_pkg.sv
// rtl/timer_ctrl_pkg.sv - shared state and mode types for the multi-channel timer.
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } ch_state_e;

  typedef enum logic {
    ONE_SHOT    = 1'b0,
    AUTO_RELOAD = 1'b1
  } mode_e;

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one independent timer channel: IDLE/RUN/PAUSE FSM,
// terminal-count counter, done pulse and sticky interrupt-pending flag.
module timer_channel
  import timer_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             pause_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             irq_ack_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             irq_pend_o
);

  ch_state_e        state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic             done_q, done_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] load_last;

  // Store T-1 so a zero load behaves as T=1 and the compare never wraps.
  assign load_last = (load_val_i == '0) ? '0 : load_val_i - CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= ONE_SHOT;
      count_q <= '0;
      last_q  <= '0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      last_q  <= last_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    count_d = count_q;
    last_d  = last_q;
    done_d  = 1'b0;
    pend_d  = done_q | (pend_q & ~irq_ack_i);
    case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          state_d = RUN;
          count_d = '0;
          last_d  = load_last;
          mode_d  = mode_e'(mode_i);
        end
      end
      RUN, PAUSE: begin
        if (stop_i) begin
          state_d = IDLE;
          count_d = '0;
        end else if (pause_i) begin
          state_d = PAUSE;
        end else begin
          // Resuming from PAUSE counts on the same edge so the delay equals the pause length.
          state_d = RUN;
          if (tick_i) begin
            if (count_q == last_q) begin
              done_d  = 1'b1;
              count_d = '0;
              if (mode_q == ONE_SHOT) begin
                state_d = IDLE;
              end else begin
                last_d = load_last;
                mode_d = mode_e'(mode_i);
              end
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign irq_pend_o = pend_q;

endmodule

// File: rtl/multi_ch_timer_ctrl.sv
// rtl/multi_ch_timer_ctrl.sv - NUM_CH independent timers with shared tick and OR-ed irq.
// Optional shared prescaler enabled by macro TIMER_PRESCALE_EN.
module multi_ch_timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 16,
  parameter int PRESC_DIV = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       pause,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH*CNT_W-1:0] load_val,
  input  logic [NUM_CH-1:0]       irq_ack,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       irq_pend,
  output logic                    irq
);

  logic tick;
  logic irq_q;

  if (NUM_CH < 1 || NUM_CH > 16 || CNT_W < 1 || PRESC_DIV < 1) begin : g_bad_param
    $error("multi_ch_timer_ctrl: parameter out of range");
  end

`ifdef TIMER_PRESCALE_EN
  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;

  // Free-running and shared, so the first tick after a start lands anywhere in 1..PRESC_DIV.
  assign tick    = (presc_q == PW'(PRESC_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_i     (tick),
      .start_i    (start[i]),
      .stop_i     (stop[i]),
      .pause_i    (pause[i]),
      .mode_i     (mode[i]),
      .load_val_i (load_val[i*CNT_W +: CNT_W]),
      .irq_ack_i  (irq_ack[i]),
      .busy_o     (busy[i]),
      .done_o     (done[i]),
      .irq_pend_o (irq_pend[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |irq_pend;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_multi_ch_timer_ctrl.sv
// tb/tb_multi_ch_timer_ctrl.sv - scoreboard bench: stimulus queues expected done windows,
// a negedge monitor matches every done pulse against them.
module tb_multi_ch_timer_ctrl;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
`ifdef TIMER_PRESCALE_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_CH-1:0]       start = '0;
  logic [NUM_CH-1:0]       stop = '0;
  logic [NUM_CH-1:0]       pause = '0;
  logic [NUM_CH-1:0]       mode = '0;
  logic [NUM_CH*CNT_W-1:0] load_val = '0;
  logic [NUM_CH-1:0]       irq_ack = '0;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;
  logic [NUM_CH-1:0]       irq_pend;
  logic                    irq;

  multi_ch_timer_ctrl #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .PRESC_DIV(DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .mode     (mode),
    .load_val (load_val),
    .irq_ack  (irq_ack),
    .busy     (busy),
    .done     (done),
    .irq_pend (irq_pend),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int lo;
    int hi;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // T ticks after the start edge; with a divider the first tick may come 1..DIV edges later.
  task automatic expect_done(input int ch, input int s, input int t);
    exp_t e;
    e.ch = ch;
    e.lo = s + (t - 1) * DIV + 1;
    e.hi = s + t * DIV;
    exp_q.push_back(e);
  endtask

  task automatic start_ch(input int ch, input int t, input logic m, output int s);
    load_val[ch*CNT_W +: CNT_W] = t[CNT_W-1:0];
    mode[ch]  = m;
    start[ch] = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    start[ch] = 1'b0;
  endtask

  task automatic ack_all();
    irq_ack = '1;
    @(negedge clk);
    irq_ack = '0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (done[ch] === 1'b1) begin
        bit found;
        found = 1'b0;
        for (int i = 0; i < exp_q.size() && !found; i++) begin
          if (exp_q[i].ch == ch && cyc >= exp_q[i].lo && cyc <= exp_q[i].hi) begin
            found = 1'b1;
            exp_q.delete(i);
          end
        end
        checks++;
        if (!found) begin
          failures++;
          $display("FAIL done_unexpected ch=%0d cyc=%0d got=1 want=0", ch, cyc);
        end
      end
    end
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].hi < cyc) begin
        checks++;
        failures++;
        $display("FAIL done_missing ch=%0d window=%0d..%0d got=0 want=1", exp_q[i].ch,
                 exp_q[i].lo, exp_q[i].hi);
        exp_q.delete(i);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pend", 32'(irq_pend), 0);
    chk("rst_irq", 32'(irq), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_irq", 32'(irq), 0);

`ifndef TIMER_PRESCALE_EN
    // ch0 one-shot T=5
    start_ch(0, 5, 1'b0, s);
    expect_done(0, s, 5);
    wait_to(s + 4);
    chk("os_busy_run", 32'(busy[0]), 1);
    wait_to(s + 5);
    chk("os_busy_at_done", 32'(busy[0]), 0);
    wait_to(s + 6);
    chk("os_busy_after", 32'(busy[0]), 0);
    chk("os_pend_set", 32'(irq_pend[0]), 1);
    wait_to(s + 7);
    chk("os_irq", 32'(irq), 1);
    irq_ack[0] = 1'b1;
    wait_to(s + 8);
    irq_ack[0] = 1'b0;
    chk("os_pend_clr", 32'(irq_pend[0]), 0);
    wait_to(s + 9);
    chk("os_irq_clr", 32'(irq), 0);

    // ch1 auto-reload T=3 for 10 cycles, then stop
    start_ch(1, 3, 1'b1, s);
    expect_done(1, s, 3);
    expect_done(1, s + 3, 3);
    expect_done(1, s + 6, 3);
    for (int k = 1; k <= 10; k++) begin
      wait_to(s + k);
      chk("ar_busy", 32'(busy[1]), 1);
    end
    stop[1] = 1'b1;
    @(negedge clk);
    stop[1] = 1'b0;
    chk("ar_stop_busy", 32'(busy[1]), 0);
    wait_to(s + 16);
    chk("ar_stop_idle", 32'(busy[1]), 0);
    ack_all();

    // ch3 T=0 acts as T=1; start+stop together stays idle
    start_ch(3, 0, 1'b0, s);
    expect_done(3, s, 1);
    wait_to(s + 1);
    chk("t0_busy", 32'(busy[3]), 0);
    load_val[3*CNT_W +: CNT_W] = 16'd4;
    start[3] = 1'b1;
    stop[3]  = 1'b1;
    @(negedge clk);
    start[3] = 1'b0;
    stop[3]  = 1'b0;
    chk("ss_busy", 32'(busy[3]), 0);
    repeat (6) @(negedge clk);
    chk("ss_idle", 32'(busy[3]), 0);
    ack_all();

    // ch2 T=6 paused for 4 edges -> done at s+10; ack coincident with done
    start_ch(2, 6, 1'b0, s);
    expect_done(2, s, 10);
    wait_to(s + 1);
    pause[2] = 1'b1;
    wait_to(s + 4);
    chk("pause_busy", 32'(busy[2]), 1);
    wait_to(s + 5);
    pause[2] = 1'b0;
    wait_to(s + 10);
    irq_ack[2] = 1'b1;
    @(negedge clk);
    irq_ack[2] = 1'b0;
    chk("ack_done_pend", 32'(irq_pend[2]), 1);
    wait_to(s + 12);
    chk("ack_done_pend2", 32'(irq_pend[2]), 1);
    ack_all();
`endif

    // ch0 T=2; with the prescaler this spans 5..8 clocks
    start_ch(0, 2, 1'b0, s);
    expect_done(0, s, 2);
    wait_to(s + 2 * DIV + 2);
    chk("t2_idle", 32'(busy[0]), 0);

    // reset pulsed mid-run: run discarded, no done
    start_ch(0, 8, 1'b0, s);
    wait_to(s + 3);
    chk("mid_busy", 32'(busy[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_pend", 32'(irq_pend), 0);
    chk("mid_rst_irq", 32'(irq), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10 * DIV) @(negedge clk);
    chk("mid_after_busy", 32'(busy), 0);
    chk("mid_after_pend", 32'(irq_pend), 0);
    chk("mid_after_irq", 32'(irq), 0);

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
